alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 26 ++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Requester and shared-ALU signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface alu_arbiter_if;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic [15:0] res;
  logic        zero_f, carry_f;
  logic        busy;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_y;
  logic        alu_zero, alu_carry;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_y, alu_zero, alu_carry,
    output gnt0, gnt1, done0, done1, res, zero_f, carry_f, busy, alu_a, alu_b, alu_op
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_y, alu_zero, alu_carry,
    input  gnt0, gnt1, done0, done1, res, zero_f, carry_f, busy, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// state | meaning
// IDLE  | waiting for a request; arbitration and operand capture happen here
// EXEC  | captured operands on the ALU; gnt of the winner high
// DONE  | result registered; done of the winner high
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic [15:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        busy_q, busy_d;
  logic        any_req;
  logic        pick;

  always_comb begin
    any_req = bus.req0 | bus.req1;
    // On a tie the round-robin choice is whoever was not granted last
    if (bus.req0 && bus.req1) begin
      pick = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      pick = bus.req1;
    end

    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    res_d    = res_q;
    zero_d   = zero_q;
    carry_d  = carry_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = EXEC;
          win_d    = pick;
          last_d   = pick;
          alu_op_d = pick ? bus.op1 : bus.op0;
          alu_a_d  = pick ? bus.a1  : bus.a0;
          alu_b_d  = pick ? bus.b1  : bus.b0;
          gnt0_d   = ~pick;
          gnt1_d   = pick;
        end
      end
      EXEC: begin
        state_d = DONE;
        res_d   = bus.alu_y;
        zero_d  = bus.alu_zero;
        carry_d = (alu_op_q == 3'b010) ? bus.alu_carry : 1'b0;
        done0_d = ~win_q;
        done1_d = win_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      alu_op_q <= 3'd0;
      alu_a_q  <= 16'd0;
      alu_b_q  <= 16'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      res_q    <= 16'd0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.res     = res_q;
  assign bus.zero_f  = zero_q;
  assign bus.carry_f = carry_q;
  assign bus.busy    = busy_q;
  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;
  assign bus.alu_op  = alu_op_q;

endmodule
